// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO feeding an 8N1 UART transmitter
module uart_tx_fifo #(
    parameter int CLK_FREQ   = 50000000,
    parameter int UART_BPS   = 115200,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          tx_wr,
    input  logic [7:0]                    tx_data,
    output logic                          tx_full,
    output logic [$clog2(FIFO_DEPTH):0]   tx_count,
    output logic                          tx_overflow,
    output logic                          uart_tx_busy,
    output logic                          uart_txd
);
    localparam int BAUD_CNT = CLK_FREQ / UART_BPS;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int BW = $clog2(BAUD_CNT + 1);
    localparam logic [1:0] IDLE = 2'd0, START = 2'd1, DATA = 2'd2, STOP = 2'd3;
    logic [1:0]    state;
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [BW-1:0] baud_cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic          wr_ok, baud_end, pop;
    assign tx_full      = tx_count == (AW+1)'(FIFO_DEPTH);
    assign wr_ok        = tx_wr && !tx_full;
    assign baud_end     = baud_cnt == BW'(BAUD_CNT - 1);
    // a pop happens from IDLE or at the last clock of STOP, so frames run back-to-back
    assign pop          = tx_count != '0 && (state == IDLE || (state == STOP && baud_end));
    assign uart_tx_busy = state != IDLE;
    // storage array carries no reset; only pointers and count define its contents
    always_ff @(posedge clk)
        if (wr_ok) mem[wr_ptr] <= tx_data;
    // circular-buffer pointers, occupancy and the dropped-write pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            tx_count    <= '0;
            tx_overflow <= 1'b0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            tx_count    <= tx_count + (AW+1)'(wr_ok) - (AW+1)'(pop);
            tx_overflow <= tx_wr && tx_full;
        end
    end
    // frame sequencer: baud timing, bit index and the registered serial line
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
            uart_txd <= 1'b1;
        end else begin
            baud_cnt <= (state == IDLE || baud_end) ? '0 : baud_cnt + 1'b1;
            if (pop) begin
                state    <= START;
                shreg    <= mem[rd_ptr];
                uart_txd <= 1'b0;
            end else if (baud_end && state == START) begin
                state    <= DATA;
                bit_idx  <= '0;
                uart_txd <= shreg[0];
            end else if (baud_end && state == DATA) begin
                state    <= bit_idx == 3'd7 ? STOP : DATA;
                bit_idx  <= bit_idx + 3'd1;
                uart_txd <= bit_idx == 3'd7 ? 1'b1 : shreg[bit_idx + 3'd1];
            end else if (baud_end && state == STOP) begin
                state    <= IDLE;
            end
        end
    end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed checks of queuing, framing, overflow and reset with BAUD_CNT=4
module tb_uart_tx_fifo;
    localparam int BAUD  = 4;
    localparam int FRAME = 10 * BAUD;
    logic       clk, rst, tx_wr, tx_full, tx_overflow, uart_tx_busy, uart_txd;
    logic [7:0] tx_data;
    logic [4:0] tx_count;
    int         checks = 0, errors = 0, cyc = 0, n, s;
    logic [7:0] rx_q[$], exp_q[$];
    int         rx_t[$];
    int         mon_t;
    logic [7:0] mon_d;
    uart_tx_fifo #(.CLK_FREQ(1000), .UART_BPS(250), .FIFO_DEPTH(16)) dut (
        .clk(clk), .rst(rst), .tx_wr(tx_wr), .tx_data(tx_data), .tx_full(tx_full),
        .tx_count(tx_count), .tx_overflow(tx_overflow), .uart_tx_busy(uart_tx_busy),
        .uart_txd(uart_txd)
    );
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic push(input logic [7:0] b);
        tx_wr = 1'b1;
        tx_data = b;
        @(negedge clk);
    endtask
    task automatic write(input logic [7:0] b, output int t);
        push(b);
        t = cyc;
        tx_wr = 1'b0;
    endtask
    task automatic wait_cyc(input int c);
        while (cyc < c) @(negedge clk);
    endtask
    task automatic wait_rx(input int cnt);
        int k = 0;
        while (rx_q.size() < cnt && k < 3000) begin
            @(negedge clk);
            k++;
        end
        if (rx_q.size() < cnt) check("rx_timeout", rx_q.size(), cnt);
    endtask
    task automatic check_frames(input bit contig);
        wait_rx(exp_q.size());
        check("frame_cnt", rx_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
            check($sformatf("frame%0d", i), rx_q[i], exp_q[i]);
            if (contig && i > 0) check($sformatf("gap%0d", i), rx_t[i] - rx_t[i-1], FRAME);
        end
        wait_cyc(cyc + 5);
        rx_q.delete();
        rx_t.delete();
        exp_q.delete();
    endtask
    // line receiver sampling each bit at its centre
    initial forever begin
        @(negedge clk);
        if (!rst && uart_txd === 1'b0) begin
            mon_t = cyc;
            repeat (BAUD/2) @(negedge clk);
            check("start_bit", uart_txd, 0);
            for (int i = 0; i < 8; i++) begin
                repeat (BAUD) @(negedge clk);
                mon_d[i] = uart_txd;
            end
            repeat (BAUD) @(negedge clk);
            check("stop_bit", uart_txd, 1);
            rx_q.push_back(mon_d);
            rx_t.push_back(mon_t);
        end
    end
    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end
    initial begin
        rst = 1'b1;
        tx_wr = 1'b0;
        tx_data = '0;
        #12;
        check("rst_txd", uart_txd, 1);
        check("rst_busy", uart_tx_busy, 0);
        check("rst_count", tx_count, 0);
        check("rst_full", tx_full, 0);
        check("rst_ovf", tx_overflow, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        // single byte: start 2 edges after the write, busy exactly one frame
        write(8'h55, n);
        s = n + 1;
        wait_rx(1);
        if (rx_t.size() > 0) check("latency", rx_t[0] - n, 1);
        wait_cyc(s + FRAME - 1);
        check("single_busy_end", uart_tx_busy, 1);
        wait_cyc(s + FRAME);
        check("single_idle", uart_tx_busy, 0);
        exp_q.push_back(8'h55);
        check_frames(0);
        // back-to-back writes
        push(8'hA5);
        n = cyc;
        push(8'h3C);
        push(8'hFF);
        tx_wr = 1'b0;
        s = n + 1;
        check("b2b_count", tx_count, 2);
        wait_cyc(s + FRAME - 1);
        check("b2b_count_pre", tx_count, 2);
        wait_cyc(s + FRAME);
        check("b2b_count_pop1", tx_count, 1);
        wait_cyc(s + 2*FRAME);
        check("b2b_count_pop2", tx_count, 0);
        wait_cyc(s + 3*FRAME - 1);
        check("b2b_busy_end", uart_tx_busy, 1);
        wait_cyc(s + 3*FRAME);
        check("b2b_idle", uart_tx_busy, 0);
        exp_q = '{8'hA5, 8'h3C, 8'hFF};
        check_frames(1);
        // fill while busy, then overflow
        write(8'h11, n);
        exp_q.push_back(8'h11);
        for (int j = 0; j < 16; j++) begin
            push(8'h20 + 8'(j));
            exp_q.push_back(8'h20 + 8'(j));
            if (j == 14) check("full_at_15", tx_full, 0);
        end
        check("full_at_16", tx_full, 1);
        check("count_16", tx_count, 16);
        push(8'hEE);
        tx_wr = 1'b0;
        check("ovf_pulse", tx_overflow, 1);
        check("ovf_count", tx_count, 16);
        @(negedge clk);
        check("ovf_clear", tx_overflow, 0);
        check_frames(1);
        // write dropped at full even while STOP pops
        write(8'h01, n);
        s = n + 1;
        exp_q.push_back(8'h01);
        for (int j = 0; j < 16; j++) begin
            push(8'h40 + 8'(j));
            exp_q.push_back(8'h40 + 8'(j));
        end
        tx_wr = 1'b0;
        wait_cyc(s + FRAME - 1);
        check("pre_pop_full", tx_full, 1);
        push(8'hEE);
        tx_wr = 1'b0;
        check("pop_ovf", tx_overflow, 1);
        check("pop_ovf_count", tx_count, 15);
        check_frames(1);
        // write and pop on the same edge keep the count
        write(8'h02, n);
        s = n + 1;
        exp_q.push_back(8'h02);
        for (int j = 0; j < 5; j++) begin
            push(8'h60 + 8'(j));
            exp_q.push_back(8'h60 + 8'(j));
        end
        tx_wr = 1'b0;
        wait_cyc(s + FRAME - 1);
        check("wp_count_pre", tx_count, 5);
        push(8'h77);
        tx_wr = 1'b0;
        exp_q.push_back(8'h77);
        check("wp_count", tx_count, 5);
        check("wp_no_ovf", tx_overflow, 0);
        check_frames(1);
        // stream of random bytes across pointer wrap
        for (int k = 0; k < 5000 && exp_q.size() < 40; k++) begin
            if (!tx_full) begin
                tx_wr = 1'b1;
                tx_data = 8'($urandom);
                exp_q.push_back(tx_data);
            end else begin
                tx_wr = 1'b0;
            end
            @(negedge clk);
        end
        tx_wr = 1'b0;
        check_frames(0);
        // reset in the middle of data bit 4
        write(8'hC3, n);
        s = n + 1;
        push(8'h99);
        tx_wr = 1'b0;
        wait_cyc(s + 5*BAUD + 1);
        check("pre_rst_txd", uart_txd, 0);
        check("pre_rst_count", tx_count, 1);
        rst = 1'b1;
        #1;
        check("arst_txd", uart_txd, 1);
        check("arst_busy", uart_tx_busy, 0);
        check("arst_count", tx_count, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        wait_cyc(cyc + FRAME + 5);
        rx_q.delete();
        rx_t.delete();
        write(8'h5A, n);
        wait_rx(1);
        if (rx_t.size() > 0) check("post_rst_latency", rx_t[0] - n, 1);
        wait_cyc(cyc + FRAME + 10);
        exp_q.push_back(8'h5A);
        check_frames(0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
